// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
// Request/response bundle between the EX stage and the multiply/divide
// sequencer.
//   master (pipeline side): drives start, funct3, data1, data2, flush;
//                           sees busy, stall, valid, result.
//   slave  (sequencer)    : the mirror image of master.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, data1, data2, flush,
    input  busy, stall, valid, result
  );

  modport slave (
    input  start, funct3, data1, data2, flush,
    output busy, stall, valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle RV32M controller. An operation is accepted in IDLE, operands
// are latched, and the pipeline is stalled while a registered multiplier
// settles (MUL_LATENCY cycles) or a restoring divider iterates (XLEN cycles).
// The result is presented with a one-cycle valid pulse and held afterwards.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - muldiv_sequencer_if.slave (start/funct3/data1/data2/flush in,
//            busy/stall/valid/result out)
module muldiv_sequencer #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's complement magnitude; the most negative value maps onto itself
  // and is then treated as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn & v[XLEN-1]) ? (XLEN'(0) - v) : v;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;       // funct3[1:0] of the accepted op
  logic [XLEN-1:0] a_q, a_d;         // raw rs1
  logic [XLEN-1:0] b_q, b_d;         // raw rs2
  logic [XLEN:0]   rem_q, rem_d;     // one extra bit so the trial subtract never overflows
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;

  logic              accept_s, div0_s, ovf_s, div_sgn_s;
  logic              a_sgn_s, b_sgn_s;
  logic [2*XLEN-1:0] ma_s, mb_s, prod_s;
  logic [XLEN:0]     shift_s, diff_s, rem_nx_s;
  logic [XLEN-1:0]   quo_nx_s, quo_fix_s, rem_fix_s;
  logic              ge_s, q_neg_s, r_neg_s;

  assign accept_s  = (state_q == S_IDLE) & bus.start & ~bus.flush;
  assign div_sgn_s = ~bus.funct3[0];
  assign div0_s    = (bus.data2 == {XLEN{1'b0}});
  assign ovf_s     = div_sgn_s & (bus.data1 == {1'b1, {(XLEN-1){1'b0}}})
                               & (bus.data2 == {XLEN{1'b1}});

  // Multiplier: sign-extend to 2*XLEN and keep the low 2*XLEN bits of the
  // product, which is the exact signed/unsigned/mixed result.
  assign a_sgn_s = (op_q == 2'b01) | (op_q == 2'b10);
  assign b_sgn_s = (op_q == 2'b01);
  assign ma_s    = {{XLEN{a_sgn_s & a_q[XLEN-1]}}, a_q};
  assign mb_s    = {{XLEN{b_sgn_s & b_q[XLEN-1]}}, b_q};
  assign prod_s  = ma_s * mb_s;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign shift_s  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign diff_s   = shift_s - {1'b0, dvs_q};
  assign ge_s     = ~diff_s[XLEN];
  assign rem_nx_s = ge_s ? diff_s : shift_s;
  assign quo_nx_s = {quo_q[XLEN-2:0], ge_s};

  assign q_neg_s   = ~op_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg_s   = ~op_q[0] & a_q[XLEN-1];
  assign quo_fix_s = q_neg_s ? (XLEN'(0) - quo_nx_s) : quo_nx_s;
  assign rem_fix_s = r_neg_s ? (XLEN'(0) - rem_nx_s[XLEN-1:0]) : rem_nx_s[XLEN-1:0];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d = bus.funct3[1:0];
          a_d  = bus.data1;
          b_d  = bus.data2;
          if (!bus.funct3[2]) begin
            state_d = S_MUL;
            cnt_d   = CW'(MUL_LATENCY - 1);
          end else if (div0_s) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = bus.funct3[1] ? bus.data1 : {XLEN{1'b1}};
          end else if (ovf_s) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = bus.funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
          end else begin
            state_d = S_DIV;
            cnt_d   = CW'(XLEN - 1);
            rem_d   = {(XLEN+1){1'b0}};
            quo_d   = mag(bus.data1, div_sgn_s);
            dvs_d   = mag(bus.data2, div_sgn_s);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = (op_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        rem_d = rem_nx_s;
        quo_d = quo_nx_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = op_q[1] ? rem_fix_s : quo_fix_s;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A kill overrides everything: no result, no pulse.
    if (bus.flush) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end else begin
      valid_d  = valid_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 2'b00;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      rem_q    <= {(XLEN+1){1'b0}};
      quo_q    <= {XLEN{1'b0}};
      dvs_q    <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Stall must already be high in the accept cycle, so it looks at start;
  // it is gated by rst_n so it drops the moment reset asserts.
  assign bus.stall  = rst_n & (accept_s | (state_q == S_MUL) | (state_q == S_DIV));
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] last_exp = 32'h0000_0000;

  muldiv_sequencer_if #(.XLEN(32)) ifc ();

  muldiv_sequencer #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse pops one expected response.
  always @(negedge clk) begin
    if (rst_n && ifc.valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", ifc.result, mon_e.res);
        chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Drive one request for one cycle; lat=0 means no response is expected.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit chk_stall);
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.funct3 = f3;
    ifc.data1  = a;
    ifc.data2  = b;
    if (lat > 0) begin
      sb_q.push_back('{exp, cyc + lat});
      last_exp = exp;
    end
    if (chk_stall) begin
      #1 chk("stall_accept", 32'(ifc.stall), 32'd1);
    end
    @(posedge clk);
    #1 ifc.start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && !ifc.busy) ok = 1'b1;
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    ifc.start  = 1'b0;
    ifc.funct3 = 3'b000;
    ifc.data1  = 32'h0000_0000;
    ifc.data2  = 32'h0000_0000;
    ifc.flush  = 1'b0;

    // Reset state; stall must stay low even with start asserted.
    #2 ifc.start = 1'b1;
    #1;
    chk("rst_busy",   32'(ifc.busy),  32'd0);
    chk("rst_stall",  32'(ifc.stall), 32'd0);
    chk("rst_valid",  32'(ifc.valid), 32'd0);
    chk("rst_result", ifc.result,     32'h0000_0000);
    ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiplies: valid in cycle 3.
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, 1'b1); wait_done();
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1'b0); wait_done();
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 3, 1'b0); wait_done();
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3, 1'b0); wait_done();
    issue(3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 3, 1'b0); wait_done();

    // DIV -7/2 with stall profile: high cycles 0..32, low in 33.
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b1);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (ifc.stall !== 1'b1) bad++;
    end
    chk("stall_while_div", 32'(bad), 32'd0);
    @(negedge clk);
    #1 chk("stall_in_done", 32'(ifc.stall), 32'd0);
    wait_done();

    issue(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0); wait_done();
    issue(3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b0); wait_done();
    issue(3'b111, 32'd100,       32'd7,         32'd2,         33, 1'b0); wait_done();
    issue(3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33, 1'b0); wait_done();
    issue(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0); wait_done();
    issue(3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0); wait_done();
    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, 1'b0); wait_done();
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0); wait_done();

    // Special cases: result in cycle 1.
    issue(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0); wait_done();
    issue(3'b110, 32'd5,         32'd0,         32'h0000_0005, 1, 1'b0); wait_done();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0); wait_done();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0); wait_done();

    // Flush in cycle 10 of a divide; a new start in cycle 11 is accepted.
    issue(3'b100, 32'd1000, 32'd3, 32'h0000_0000, 0, 1'b0);
    repeat (10) @(negedge clk);
    ifc.flush = 1'b1;
    @(posedge clk);
    #1 ifc.flush = 1'b0;
    chk("flush_busy",   32'(ifc.busy),  32'd0);
    chk("flush_valid",  32'(ifc.valid), 32'd0);
    chk("flush_result", ifc.result,     last_exp);
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0); wait_done();

    // Start while busy (and still high in DONE) with other operands is ignored.
    issue(3'b101, 32'd50, 32'd5, 32'd10, 33, 1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    ifc.start  = 1'b1;
    ifc.funct3 = 3'b101;
    ifc.data1  = 32'd200;
    ifc.data2  = 32'd3;
    repeat (28) @(negedge clk);
    @(posedge clk);
    #1 ifc.start = 1'b0;
    chk("done_to_idle_busy", 32'(ifc.busy), 32'd0);
    wait_done();

    // Reset in the middle of a multiply.
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    last_exp = 32'h0000_0000;
    #1;
    chk("midrst_busy",   32'(ifc.busy),  32'd0);
    chk("midrst_stall",  32'(ifc.stall), 32'd0);
    chk("midrst_valid",  32'(ifc.valid), 32'd0);
    chk("midrst_result", ifc.result,     32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b000, 32'd3, 32'd4, 32'h0000_000C, 3, 1'b0); wait_done();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
